// File: rtl/dbg_pkg.sv
// dbg_pkg: shared types for the commit debug path.
//   debug_st    - one committed instruction as the trace path packs it
//   chk_err_e   - error class reported by commit_checker
//   chk_state_e - checker FSM states
//   FLD_*       - bit positions inside the err_fields mismatch mask
//   chk_mask()  - per-field comparison of a DUT event against a golden record
package dbg_pkg;

  typedef struct packed {
    logic [1:0]  op_type;       // {write_mem, write_reg}
    logic [4:0]  reg_id;
    logic [31:0] reg_data;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic [31:0] pc_cur;
    logic [31:0] debug_inst_h;
    logic [31:0] debug_inst_l;
  } debug_st;

  typedef enum logic [1:0] {
    CHK_NONE     = 2'd0,
    CHK_MISMATCH = 2'd1,
    CHK_OVERFLOW = 2'd2
  } chk_err_e;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } chk_state_e;

  localparam int FLD_OP    = 0;
  localparam int FLD_REG   = 1;
  localparam int FLD_MADDR = 2;
  localparam int FLD_MDATA = 3;
  localparam int FLD_PC    = 4;
  localparam int FLD_INST  = 5;

  // The golden record's op_type decides which payload fields are meaningful.
  // A write to x0 has no architectural effect, so its data is not compared.
  function automatic logic [5:0] chk_mask(input debug_st dut_r, input debug_st exp_r);
    logic [5:0] m;
    m = '0;
    m[FLD_OP]   = (dut_r.op_type != exp_r.op_type);
    m[FLD_PC]   = (dut_r.pc_cur != exp_r.pc_cur);
    m[FLD_INST] = (dut_r.debug_inst_h != exp_r.debug_inst_h) ||
                  (dut_r.debug_inst_l != exp_r.debug_inst_l);
    if (exp_r.op_type[0]) begin
      m[FLD_REG] = (dut_r.reg_id != exp_r.reg_id) ||
                   ((exp_r.reg_id != 5'd0) && (dut_r.reg_data != exp_r.reg_data));
    end
    if (exp_r.op_type[1]) begin
      m[FLD_MADDR] = (dut_r.mem_addr != exp_r.mem_addr);
      m[FLD_MDATA] = (dut_r.mem_data != exp_r.mem_data);
    end
    return m;
  endfunction

endpackage

// File: rtl/commit_checker_if.sv
// commit_checker_if: debug taps, golden-record stream and checker results.
//   debug_*     pipeline commit taps (driven by the pipeline / harness)
//   exp_valid / exp_rec / exp_ready   golden-model record stream
//   match_cnt, err, err_kind, err_index, err_fields   checker status
// Modports: slave = checker side, master = harness side.
interface commit_checker_if
  import dbg_pkg::*;
#(
  parameter int CNT_W = 32
) ();

  logic [37:0]      debug_inst;
  logic             debug_write_reg;
  logic [4:0]       debug_reg_id;
  logic [31:0]      debug_reg_data;
  logic             debug_write_mem;
  logic [31:0]      debug_mem_addr;
  logic [31:0]      debug_mem_data;
  logic [31:0]      debug_pc_cur;

  logic             exp_valid;
  debug_st          exp_rec;
  logic             exp_ready;

  logic [CNT_W-1:0] match_cnt;
  logic             err;
  chk_err_e         err_kind;
  logic [CNT_W-1:0] err_index;
  logic [5:0]       err_fields;

  modport slave (
    input  debug_inst, debug_write_reg, debug_reg_id, debug_reg_data,
           debug_write_mem, debug_mem_addr, debug_mem_data, debug_pc_cur,
           exp_valid, exp_rec,
    output exp_ready, match_cnt, err, err_kind, err_index, err_fields
  );

  modport master (
    output debug_inst, debug_write_reg, debug_reg_id, debug_reg_data,
           debug_write_mem, debug_mem_addr, debug_mem_data, debug_pc_cur,
           exp_valid, exp_rec,
    input  exp_ready, match_cnt, err, err_kind, err_index, err_fields
  );

endinterface

// File: rtl/commit_checker_fifo.sv
// commit_fifo: synchronous FIFO of debug_st records, asynchronous active-high reset.
//   clk, rst     clock / reset
//   push, push_data   write request; accepted when not full, or when full with a pop in the same cycle
//   pop, pop_data     read request; pop_data shows the head (valid when !empty)
//   full, empty, count   occupancy status
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module commit_fifo
  import dbg_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  debug_st                push_data,
  input  logic                   pop,
  output debug_st                pop_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);

  debug_st     mem [DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        do_push;
  logic        do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset; the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/commit_checker.sv
// commit_checker: compares the pipeline's commit event stream, in order, against
// golden records and latches the first mismatch or FIFO overflow.
//   clk, rst   single clock, asynchronous active-high reset
//   dbg        commit_checker_if.slave: debug_* taps in, exp_valid/exp_rec in,
//              exp_ready out, match_cnt/err/err_kind/err_index/err_fields out
// Parameters: DEPTH (event FIFO entries, power of 2, >=2), CNT_W (counter width).
module commit_checker
  import dbg_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  commit_checker_if.slave  dbg
);

  localparam int AW = $clog2(DEPTH);

  chk_state_e       state_q;
  chk_state_e       state_d;

  debug_st          cap_rec;
  debug_st          head_rec;
  logic             capture;
  logic             push;
  logic             pop;
  logic             full;
  logic             empty;
  logic [AW:0]      fifo_count;

  logic             cmp_valid_q;
  debug_st          cmp_dut_q;
  debug_st          cmp_exp_q;
  logic [5:0]       cmp_fields;

  logic             mismatch;
  logic             overflow;
  logic             match_inc;
  logic [CNT_W-1:0] match_nxt;

  logic [CNT_W-1:0] match_q;
  logic             err_q;
  chk_err_e         kind_q;
  logic [CNT_W-1:0] index_q;
  logic [5:0]       fields_q;

  assign capture = dbg.debug_write_reg | dbg.debug_write_mem;

  // Same packing as the DPI trace path so records compare bit-for-bit.
  always_comb begin
    cap_rec              = '0;
    cap_rec.op_type      = {dbg.debug_write_mem, dbg.debug_write_reg};
    cap_rec.reg_id       = dbg.debug_reg_id;
    cap_rec.reg_data     = dbg.debug_reg_data;
    cap_rec.mem_addr     = dbg.debug_mem_addr;
    cap_rec.mem_data     = dbg.debug_mem_data;
    cap_rec.pc_cur       = dbg.debug_pc_cur;
    cap_rec.debug_inst_h = {26'd0, dbg.debug_inst[37:32]};
    cap_rec.debug_inst_l = dbg.debug_inst[31:0];
  end

  commit_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (cap_rec),
    .pop       (pop),
    .pop_data  (head_rec),
    .full      (full),
    .empty     (empty),
    .count     (fifo_count)
  );

  assign cmp_fields = chk_mask(cmp_dut_q, cmp_exp_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  // When a mismatch and an overflow coincide the mismatch is the one reported,
  // so the overflow path is qualified by !mismatch in the register block.
  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    push      = 1'b0;
    mismatch  = 1'b0;
    overflow  = 1'b0;
    match_inc = 1'b0;
    case (state_q)
      RUN: begin
        pop       = dbg.exp_valid && !empty;
        mismatch  = cmp_valid_q && (cmp_fields != 6'd0);
        match_inc = cmp_valid_q && (cmp_fields == 6'd0);
        push      = capture && (!full || pop);
        overflow  = capture && full && !pop;
        if (mismatch || overflow) state_d = HALT;
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = HALT;
      end
    endcase
  end

  assign match_nxt = (match_inc && (match_q != '1)) ? match_q + CNT_W'(1) : match_q;

  // Compare stage: the popped head and the golden record are compared one
  // cycle after the handshake, keeping the mask logic off the FIFO read path.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmp_valid_q <= 1'b0;
      cmp_dut_q   <= '0;
      cmp_exp_q   <= '0;
    end else begin
      cmp_valid_q <= pop;
      if (pop) begin
        cmp_dut_q <= head_rec;
        cmp_exp_q <= dbg.exp_rec;
      end
    end
  end

  // The dropped event's index is the number of events accepted before it:
  // those already matched (including one matching this cycle) plus those buffered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      match_q  <= '0;
      err_q    <= 1'b0;
      kind_q   <= CHK_NONE;
      index_q  <= '0;
      fields_q <= '0;
    end else if (state_q == RUN) begin
      match_q <= match_nxt;
      if (mismatch) begin
        err_q    <= 1'b1;
        kind_q   <= CHK_MISMATCH;
        index_q  <= match_q;
        fields_q <= cmp_fields;
      end else if (overflow) begin
        err_q    <= 1'b1;
        kind_q   <= CHK_OVERFLOW;
        index_q  <= match_nxt + CNT_W'(fifo_count);
        fields_q <= '0;
      end
    end
  end

  assign dbg.exp_ready  = pop;
  assign dbg.match_cnt  = match_q;
  assign dbg.err        = err_q;
  assign dbg.err_kind   = kind_q;
  assign dbg.err_index  = index_q;
  assign dbg.err_fields = fields_q;

endmodule
